// File: rtl/usb_ep_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// usb_ep_stream_reader_pkg
// Shared constants and types for the endpoint stream reader:
//   - FSM state encodings (8-bit one-hot, same style as the function controller)
//   - buffer-memory select value for the Wishbone address MSB
//   - endpoint-1 buffer pointers, buffer length / pointer widths
//   - len_to_words(): byte count -> whole 32-bit word count
// `USBF_UFC_HADR normally comes from usbf_defines; the fallback below matches
// the USB core's 17-bit buffer-memory address.
// -----------------------------------------------------------------------------
`ifndef USBF_UFC_HADR
`define USBF_UFC_HADR 17
`endif

package usb_ep_stream_reader_pkg;

  typedef enum logic [7:0] {
    ST_IDLE  = 8'b0000_0001,
    ST_CHECK = 8'b0000_0010,
    ST_REQ   = 8'b0000_0100,
    ST_DONE  = 8'b0000_1000,
    ST_ERR   = 8'b0001_0000
  } state_e;

  localparam logic        BUF_MEM_SEL  = 1'b0;       // address MSB: buffer memory
  localparam int          BUF_LEN_W    = 14;
  localparam int          BUF_PTR_W    = 17;
  localparam int          WORD_CNT_W   = 12;
  localparam logic [16:0] EP1_BUF0_PTR = 17'h02000;
  localparam logic [16:0] EP1_BUF1_PTR = 17'h03000;

  // Round a byte count up to whole words, kept to the 12-bit word counter.
  function automatic logic [WORD_CNT_W-1:0] len_to_words(input logic [BUF_LEN_W-1:0] len);
    logic [BUF_LEN_W:0] t;
    t = {1'b0, len} + (BUF_LEN_W+1)'(3);
    return t[WORD_CNT_W+1:2];
  endfunction

endpackage

// File: rtl/usb_ep_stream_reader_smp_fifo.sv
// -----------------------------------------------------------------------------
// smp_fifo
// Synchronous first-word-fall-through FIFO with occupancy output.
//   clk_i, nrst_i : clock, synchronous active-low reset (empties the FIFO)
//   push_i/data_i : write a word (accepted when not full, or full with a pop)
//   pop_i         : consume the head word; ignored when empty
//   data_o        : head word, forced to 0 while empty
//   valid_o       : FIFO non-empty
//   level_o       : number of stored words
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module smp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      lvl_q;
  logic             empty, full, do_push, do_pop;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: only words below the level are ever visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = empty ? '0 : mem_q[rd_q];
  assign valid_o = !empty;
  assign level_o = lvl_q;

endmodule

// File: rtl/usb_ep_stream_reader.sv
// -----------------------------------------------------------------------------
// usb_ep_stream_reader
// Wishbone read master that drains one filled endpoint buffer into a sample
// FIFO and presents the words on a valid/ready stream.
//   clk_i, nrst_i        : clock, synchronous active-low reset
//   start_i              : pulse, drain buffer at buf_ptr_i of buf_len_i bytes
//   busy_o/done_o/err_o  : transfer in progress / finished / Wishbone timeout
//   wb_*                 : Wishbone master (read-only, single reads)
//   smp_data_o/valid_o/ready_i : sample stream (FIFO head, FWFT)
//   fifo_level_o         : FIFO occupancy
// Build option: USB_EP_STREAM_BYTESWAP_EN byte-reverses each word before it
// enters the FIFO (USB little-endian -> MSB-first for the DAC path).
// -----------------------------------------------------------------------------
`ifndef USBF_UFC_HADR
`define USBF_UFC_HADR 17
`endif

module usb_ep_stream_reader
  import usb_ep_stream_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk_i,
  input  logic                        nrst_i,
  input  logic                        start_i,
  input  logic [16:0]                 buf_ptr_i,
  input  logic [13:0]                 buf_len_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [`USBF_UFC_HADR:0]     wb_addr_o,
  input  logic [31:0]                 wb_data_i,
  input  logic                        wb_ack_i,
  output logic                        wb_we_o,
  output logic                        wb_stb_o,
  output logic                        wb_cyc_o,
  output logic [31:0]                 smp_data_o,
  output logic                        smp_valid_o,
  input  logic                        smp_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_e                  state_q, state_d;
  logic [BUF_PTR_W-1:0]    ptr_q, ptr_d;
  logic [WORD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]              tmo_q, tmo_d;
  logic                    push;
  logic [31:0]             push_data;
  logic                    fifo_room;

  // A push only happens in REQ and lands at the edge leaving it, so by the
  // time CHECK looks at the level any pending push is already counted.
  assign fifo_room = (fifo_level_o < LVL_W'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;               // timeout counter is zero outside REQ
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ptr_d   = {buf_ptr_i[16:2], 2'b00};
          cnt_d   = len_to_words(buf_len_i);
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cnt_q == '0)    state_d = ST_DONE;   // zero-length buffer
        else if (fifo_room) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (wb_ack_i) begin
          push    = 1'b1;
          ptr_d   = ptr_q + 17'd4;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == 12'd1) ? ST_DONE : ST_CHECK;
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_ERR;     // strobe held for exactly TIMEOUT cycles
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign err_o     = (state_q == ST_ERR);
  assign wb_cyc_o  = (state_q == ST_REQ);
  assign wb_stb_o  = (state_q == ST_REQ);
  assign wb_we_o   = 1'b0;
  assign wb_addr_o = {BUF_MEM_SEL, ptr_q[`USBF_UFC_HADR-1:0]};

`ifdef USB_EP_STREAM_BYTESWAP_EN
  assign push_data = {wb_data_i[7:0], wb_data_i[15:8], wb_data_i[23:16], wb_data_i[31:24]};
`else
  assign push_data = wb_data_i;
`endif

  smp_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (smp_ready_i),
    .data_o  (smp_data_o),
    .valid_o (smp_valid_o),
    .level_o (fifo_level_o)
  );

endmodule

// File: tb/tb_usb_ep_stream_reader.sv
`ifndef USBF_UFC_HADR
`define USBF_UFC_HADR 17
`endif

module tb_usb_ep_stream_reader;
  localparam int DEPTH = 4;
  localparam int TMO   = 255;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    nrst_i = 1'b0;
  logic                    start_i = 1'b0;
  logic [16:0]             buf_ptr_i = '0;
  logic [13:0]             buf_len_i = '0;
  logic                    busy_o, done_o, err_o;
  logic [`USBF_UFC_HADR:0] wb_addr_o;
  logic [31:0]             wb_data_i = '0;
  logic                    wb_ack_i = 1'b0;
  logic                    wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0]             smp_data_o;
  logic                    smp_valid_o;
  logic                    smp_ready_i = 1'b0;
  logic [LW-1:0]           fifo_level_o;

  always #5 clk = ~clk;

  usb_ep_stream_reader #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .nrst_i(nrst_i), .start_i(start_i), .buf_ptr_i(buf_ptr_i),
    .buf_len_i(buf_len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wb_addr_o(wb_addr_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .smp_data_o(smp_data_o), .smp_valid_o(smp_valid_o),
    .smp_ready_i(smp_ready_i), .fifo_level_o(fifo_level_o)
  );

  int vecs = 0;
  int miscmp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model state ----------------
  logic [31:0] exp_q[$];        // words that must be in the sample FIFO, in order
  logic [16:0] base = '0;       // word-aligned start pointer of current transfer
  int          nread = 0;       // words read so far in current transfer
  int          words_exp = 0;   // words the transfer must read
  int          done_cnt = 0, err_cnt = 0, cyc_seen = 0;
  int          ready_mode = 0;  // 0 never, 1 always, 2 random
  int          fix_lat = -1;    // slave ack latency, -1 random 0..3
  bit          noack = 1'b0, spurious = 1'b0, fixed_en = 1'b0;
  logic [31:0] fixed_val = '0;
  logic [17:0] mon_ea;
  int          qs;

  // Buffer memory contents as seen by the slave.
  function automatic logic [31:0] mem_word(input logic [17:0] a);
    if (fixed_en) return fixed_val;
    return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
  endfunction

  function automatic logic [31:0] to_fifo(input logic [31:0] d);
`ifdef USB_EP_STREAM_BYTESWAP_EN
    return {<<8{d}};
`else
    return d;
`endif
  endfunction

  // Compare process: every cycle, DUT vs model; then apply what the next
  // rising edge will do to the model (inputs are stable from posedge+1).
  always @(negedge clk) begin
    qs = exp_q.size();
    check("fifo_level", 32'(fifo_level_o), qs);
    check("smp_valid", 32'(smp_valid_o), 32'(qs != 0));
    check("smp_data", smp_data_o, (qs != 0) ? exp_q[0] : 32'h0);
    check("wb_we", 32'(wb_we_o), 0);
    mon_ea = {1'b0, 17'(base + 17'(nread * 4))};
    if (wb_cyc_o) begin
      check("wb_addr", 32'(wb_addr_o), 32'(mon_ea));
      check("wb_stb", 32'(wb_stb_o), 1);
      check("cyc_with_fifo_room", 32'(qs < DEPTH), 1);
      check("no_overread", 32'(nread < words_exp), 1);
      cyc_seen++;
    end
    if (done_o) done_cnt++;
    if (err_o)  err_cnt++;
    if (!nrst_i) exp_q.delete();
    else begin
      if (smp_ready_i && qs != 0) void'(exp_q.pop_front());
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        exp_q.push_back(to_fifo(mem_word(mon_ea)));
        nread++;
      end
    end
  end

  // Wishbone slave: acks after a latency, optionally sprays stray acks.
  initial begin : slave
    int wcnt, lat;
    wcnt = 0; lat = 0;
    forever begin
      @(posedge clk); #1;
      if (wb_stb_o && !noack) begin
        if (wcnt >= lat) begin wb_ack_i = 1'b1; wb_data_i = mem_word(wb_addr_o); end
        else begin wb_ack_i = 1'b0; wb_data_i = $urandom; end
        wcnt++;
      end else begin
        wcnt = 0;
        lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
        wb_ack_i = spurious && !noack && ($urandom_range(0, 5) == 0);
        wb_data_i = $urandom;
      end
    end
  end

  initial begin : consumer
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       smp_ready_i = 1'b0;
        1:       smp_ready_i = 1'b1;
        default: smp_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_txn(input logic [16:0] p, input logic [13:0] l);
    base = {p[16:2], 2'b00};
    words_exp = (int'(l) + 3) / 4;
    nread = 0; done_cnt = 0; err_cnt = 0; cyc_seen = 0;
    @(posedge clk); #1;
    start_i = 1'b1; buf_ptr_i = p; buf_len_i = l;
    @(posedge clk); #1;
    start_i = 1'b0; buf_ptr_i = 17'($urandom); buf_len_i = 14'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy_o && n < budget) begin @(negedge clk); n++; end
    check({name, "_idle"}, 32'(busy_o), 0);
  endtask

  task automatic flush();
    int n;
    ready_mode = 1; n = 0;
    while (fifo_level_o != 0 && n < 50) begin @(negedge clk); n++; end
    check("flush_empty", 32'(fifo_level_o), 0);
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_cyc", 32'(wb_cyc_o), 0);
    check("rst_stb", 32'(wb_stb_o), 0);
    check("rst_addr", 32'(wb_addr_o), 0);
    check("rst_level", 32'(fifo_level_o), 0);
    check("rst_data", smp_data_o, 0);
    check("rst_valid", 32'(smp_valid_o), 0);
    @(posedge clk); #1 nrst_i = 1'b1;

    // 16 bytes at 0x2000, ack one cycle after stb, consumer stalled
    fix_lat = 1; ready_mode = 0;
    start_txn(17'h02000, 14'd16);
    @(negedge clk);
    check("t1_busy", 32'(busy_o), 1);
    check("t1_stb_early", 32'(wb_stb_o), 0);
    @(negedge clk);
    check("t1_stb_lat2", 32'(wb_stb_o), 1);
    wait_idle(200, "t1");
    check("t1_done", done_cnt, 1);
    check("t1_err", err_cnt, 0);
    check("t1_words", nread, 4);
    check("t1_level", 32'(fifo_level_o), 4);
`ifdef USB_EP_STREAM_BYTESWAP_EN
    check("t1_head", smp_data_o, 32'hFFF7A5E3);
`else
    check("t1_head", smp_data_o, 32'hE3A5F7FF);
`endif
    flush();

    // zero length: done two cycles after start, no bus traffic
    fix_lat = -1;
    start_txn(17'h02000, 14'd0);
    @(negedge clk);
    check("t2_done_early", 32'(done_o), 0);
    @(negedge clk);
    check("t2_done_at2", 32'(done_o), 1);
    wait_idle(20, "t2");
    check("t2_done_cnt", done_cnt, 1);
    check("t2_no_cyc", cyc_seen, 0);

    // 5 bytes -> 2 words
    ready_mode = 1;
    start_txn(17'h02000, 14'd5);
    wait_idle(100, "t3");
    check("t3_words", nread, 2);
    check("t3_done", done_cnt, 1);
    flush();

    // 40 bytes with the consumer stalled: fill, hold off, then resume
    ready_mode = 0;
    start_txn(17'h03000, 14'd40);
    repeat (60) @(negedge clk);
    check("t4_words_stalled", nread, 4);
    check("t4_cyc_low", 32'(wb_cyc_o), 0);
    check("t4_busy", 32'(busy_o), 1);
    check("t4_level_full", 32'(fifo_level_o), DEPTH);
    @(posedge clk); #1 start_i = 1'b1; buf_ptr_i = 17'h01000; buf_len_i = 14'd8;
    @(posedge clk); #1 start_i = 1'b0;
    ready_mode = 1;
    wait_idle(500, "t4");
    check("t4_words", nread, 10);
    check("t4_done", done_cnt, 1);
    check("t4_err", err_cnt, 0);
    flush();

    // slave never acks: timeout after TMO strobe cycles
    noack = 1'b1; ready_mode = 0;
    start_txn(17'h02000, 14'd8);
    wait_idle(400, "t5");
    check("t5_err", err_cnt, 1);
    check("t5_done", done_cnt, 0);
    check("t5_stb_cycles", cyc_seen, TMO);
    check("t5_words", nread, 0);
    noack = 1'b0;
    start_txn(17'h02010, 14'd4);
    wait_idle(100, "t5b");
    check("t5b_done", done_cnt, 1);
    check("t5b_level", 32'(fifo_level_o), 1);

    // reset in the middle of a read
    noack = 1'b1;
    start_txn(17'h02000, 14'd8);
    repeat (5) @(negedge clk);
    check("t6_in_req", 32'(wb_cyc_o), 1);
    @(posedge clk); #1 nrst_i = 1'b0;
    @(posedge clk); #1;
    check("t6_cyc", 32'(wb_cyc_o), 0);
    check("t6_stb", 32'(wb_stb_o), 0);
    check("t6_busy", 32'(busy_o), 0);
    check("t6_level", 32'(fifo_level_o), 0);
    @(posedge clk); #1 nrst_i = 1'b1; noack = 1'b0;

    // byte order of a known word
    fixed_en = 1'b1; fixed_val = 32'h11223344;
    start_txn(17'h02000, 14'd4);
    wait_idle(100, "t7");
`ifdef USB_EP_STREAM_BYTESWAP_EN
    check("t7_bswap", smp_data_o, 32'h44332211);
`else
    check("t7_bswap", smp_data_o, 32'h11223344);
`endif
    fixed_en = 1'b0;
    flush();

    // pointer wraps past the top of the 17-bit space
    ready_mode = 2;
    start_txn(17'h1FFF9, 14'd12);
    wait_idle(300, "t8");
    check("t8_words", nread, 3);

    // random transfers with random consumer and stray acks
    spurious = 1'b1;
    for (int i = 0; i < 15; i++) begin
      start_txn(17'($urandom), 14'($urandom_range(0, 64)));
      wait_idle(2000, "rnd");
      check("rnd_words", nread, words_exp);
      check("rnd_done", done_cnt, 1);
      check("rnd_err", err_cnt, 0);
    end
    spurious = 1'b0;
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
